hpt_image_sequencer: RTL
========================

HPT_IMAGE_SEQUENCER -- requirements
Module: hpt_image_sequencer

Interface
REQ-001 Parameter DWELL_CYCLES, default 50000000: minimum cycles an image stays on screen after its draw completes; legal range 0..2^26-1.
REQ-002 Parameter FIFO_DEPTH, default 4: number of pending image-change entries; power of two.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 image_in  in  10  one-hot image code from the HPT hyper-cycle FSM.
REQ-006 data_in  in  8  status byte {state[2:0], response[1:0], FRH, FSH, T3_T4}.
REQ-007 draw_ready  in  1  the drawer can accept a new draw command.
REQ-008 draw_done  in  1  one-cycle pulse from the drawer when the current draw has finished.
REQ-009 draw_start  out  1  one-cycle draw command pulse.
REQ-010 draw_index  out  4  binary image index 0..9, valid while draw_start=1 and held until the next draw_start.
REQ-011 draw_data  out  8  status byte captured with draw_index; same timing as draw_index.
REQ-012 busy  out  1  high in ISSUE, DRAW and DWELL.
REQ-013 fifo_count  out  3  number of queued entries.
REQ-014 err_onehot  out  1  sticky flag: an invalid image code was seen.
REQ-015 dropped  out  1  sticky flag: a change was lost because the FIFO was full.

Function
REQ-016 A register prev_image stores the last valid image_in; reset value 10'b0.
REQ-017 image_in is valid when exactly one bit is set.
REQ-018 A valid image_in that differs from prev_image is a change. On a change, the block pushes {bit position of image_in, data_in} into the FIFO and loads prev_image in the same edge.
REQ-019 An invalid image_in sets err_onehot, pushes nothing and leaves prev_image unchanged.
REQ-020 A push while the FIFO is full with no pop in the same cycle discards the entry and sets dropped. If a push and a pop occur together when full, both succeed.
REQ-021 The FSM has states IDLE, ISSUE, DRAW and DWELL, and resets to IDLE.
REQ-022 IDLE -> ISSUE when fifo_count != 0 and draw_ready = 1; otherwise the FSM stays in IDLE.
REQ-023 In ISSUE, draw_start = 1 for exactly one cycle, the FIFO head is popped, draw_index and draw_data are loaded from the head, and the FSM moves to DRAW.
REQ-024 In DRAW, the FSM waits for draw_done. When draw_done arrives:
  - if DWELL_CYCLES = 0, it goes to IDLE;
  - otherwise it goes to DWELL with the counter loaded to DWELL_CYCLES-1.
REQ-025 In DWELL, the counter decrements each cycle; at count 0 the FSM goes to IDLE. The dwell therefore lasts exactly DWELL_CYCLES cycles.
REQ-026 draw_done is ignored in IDLE, ISSUE and DWELL.
REQ-027 Latency: with the FSM in IDLE, the FIFO empty and draw_ready = 1, a change presented in cycle t produces draw_start = 1 in cycle t+2.
REQ-028 Changes arriving during ISSUE, DRAW or DWELL are queued and issued in arrival order.
REQ-029 fifo_count equals pushes minus pops and never exceeds FIFO_DEPTH; the read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 When reset = 1 at a clock edge, the block sets:
  - FSM to IDLE;
  - FIFO emptied (fifo_count = 0);
  - prev_image = 0 and dwell counter = 0;
  - draw_start = 0, draw_index = 0, draw_data = 0;
  - busy = 0, err_onehot = 0, dropped = 0.
REQ-031 Reset asserted mid-draw or mid-dwell aborts the operation with no further draw_start. The first valid image after reset counts as a change.

Structure
REQ-032 A shared package hpt_pkg holds:
  - the 10 one-hot image constants;
  - the response codes (healthy 00, low 01, high 10);
  - the 3-bit HPT state encodings;
  - the image-index width (4);
  - the sequencer FSM state type.
REQ-033 The FIFO is a sub-module hpt_img_fifo, 12-bit entries, with push, pop, full, empty and count.
REQ-034 One-hot validation and encoding form a single combinational function in hpt_pkg.

Verification (DWELL_CYCLES=4, FIFO_DEPTH=4)
REQ-035 Reset, then image_in=10'b0000000001, data_in=8'h00, draw_ready=1 -> draw_start=1 two cycles later with draw_index=0, draw_data=8'h00, busy=1.
REQ-036 In DRAW, pulse draw_done -> busy stays high exactly 4 more cycles, then the FSM returns to IDLE; no draw_start while the FIFO is empty.
REQ-037 While in DRAW, step image_in through bits 1,2,3,4,5 on successive cycles -> 4 entries queued, dropped=1, fifo_count=4; after each done+dwell, draw_index issues 1,2,3,4 in order.
REQ-038 image_in=10'b0000000011, then 10'b0 -> err_onehot=1, no push, prev_image unchanged; a following valid code equal to prev_image produces no push.
REQ-039 Assert reset during DWELL with 2 entries queued -> next cycle: busy=0, fifo_count=0, err_onehot=0, dropped=0; image_in held at 10'b0000000001 -> a new draw with draw_index=0.
REQ-040 Hold draw_ready=0 with 2 entries queued -> no draw_start and the FSM stays in IDLE; raise draw_ready -> draw_start on the following cycle.

Source files
------------

// File: rtl/hpt_pkg.sv
// Shared definitions for the HPT image path: image codes, status fields,
// sequencer state type and the one-hot image decoder.
package hpt_pkg;

    localparam int IMG_N     = 10;
    localparam int IMG_IDX_W = 4;
    localparam int DATA_W    = 8;
    localparam int ENTRY_W   = IMG_IDX_W + DATA_W;
    localparam int DWELL_W   = 26;

    // One-hot image codes produced by the hyper-cycle FSM.
    localparam logic [IMG_N-1:0] IMG_0 = 10'b00_0000_0001;
    localparam logic [IMG_N-1:0] IMG_1 = 10'b00_0000_0010;
    localparam logic [IMG_N-1:0] IMG_2 = 10'b00_0000_0100;
    localparam logic [IMG_N-1:0] IMG_3 = 10'b00_0000_1000;
    localparam logic [IMG_N-1:0] IMG_4 = 10'b00_0001_0000;
    localparam logic [IMG_N-1:0] IMG_5 = 10'b00_0010_0000;
    localparam logic [IMG_N-1:0] IMG_6 = 10'b00_0100_0000;
    localparam logic [IMG_N-1:0] IMG_7 = 10'b00_1000_0000;
    localparam logic [IMG_N-1:0] IMG_8 = 10'b01_0000_0000;
    localparam logic [IMG_N-1:0] IMG_9 = 10'b10_0000_0000;

    // Response field of the status byte.
    typedef enum logic [1:0] {
        RESP_HEALTHY = 2'b00,
        RESP_LOW     = 2'b01,
        RESP_HIGH    = 2'b10
    } hpt_resp_t;

    // State field of the status byte (hyper-cycle FSM encoding).
    typedef enum logic [2:0] {
        HPT_RESET    = 3'd0,
        HPT_TX_FRH   = 3'd1,
        HPT_WAIT_FRH = 3'd2,
        HPT_TX_FSH   = 3'd3,
        HPT_WAIT_FSH = 3'd4,
        HPT_T3       = 3'd5,
        HPT_T4       = 3'd6,
        HPT_FAULT    = 3'd7
    } hpt_state_t;

    // Image sequencer control states.
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_DRAW,
        SEQ_DWELL
    } seq_state_t;

    typedef struct packed {
        logic                 valid;
        logic [IMG_IDX_W-1:0] index;
    } img_code_t;

    // Valid only when exactly one bit is set; index is that bit's position.
    function automatic img_code_t onehot_decode(input logic [IMG_N-1:0] code);
        img_code_t r;
        int        ones;
        r    = '0;
        ones = 0;
        for (int i = 0; i < IMG_N; i++) begin
            if (code[i]) begin
                ones    = ones + 1;
                r.index = IMG_IDX_W'(i);
            end
        end
        r.valid = (ones == 1);
        return r;
    endfunction

endpackage

// File: rtl/hpt_img_fifo.sv
// Pending image-change queue: power-of-two depth, wrapping pointers,
// simultaneous push and pop allowed when full.
module hpt_img_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 12,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Entry storage write.
    // NOTE: storage is not reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/hpt_image_sequencer.sv
// Turns image changes from the HPT hyper-cycle FSM into paced draw commands:
// changes are queued, issued one at a time, and each image is held on screen
// for a minimum dwell after its draw completes.
module hpt_image_sequencer
    import hpt_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [IMG_N-1:0]            image_in,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        draw_ready,
    input  logic                        draw_done,
    output logic                        draw_start,
    output logic [IMG_IDX_W-1:0]        draw_index,
    output logic [DATA_W-1:0]           draw_data,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        err_onehot,
    output logic                        dropped
);

    localparam logic [DWELL_W-1:0] DWELL_LOAD =
        (DWELL_CYCLES == 0) ? '0 : DWELL_W'(DWELL_CYCLES - 1);

    seq_state_t         state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [IMG_N-1:0]   prev_image;
    img_code_t          dec;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;

    assign pop = (state == SEQ_ISSUE);

    // Decode the incoming code and flag a change against the last valid image.
    // NOTE: defaults assigned first so no path leaves a value held (no latch).
    always_comb begin
        dec  = onehot_decode(image_in);
        push = 1'b0;
        if (dec.valid && (image_in != prev_image)) begin
            push = 1'b1;
        end
    end

    hpt_img_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data ({dec.index, data_in}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Track the last valid image and the sticky error/overflow flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_image <= '0;
            err_onehot <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            if (dec.valid) begin
                prev_image <= image_in;
            end else begin
                err_onehot <= 1'b1;
            end
            if (push && fifo_full && !pop) begin
                dropped <= 1'b1;
            end
        end
    end

    // Issue / draw / dwell sequencing with registered command outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEQ_IDLE;
            dwell_cnt  <= '0;
            draw_start <= 1'b0;
            draw_index <= '0;
            draw_data  <= '0;
            busy       <= 1'b0;
        end else begin
            draw_start <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (!fifo_empty && draw_ready) begin
                        state      <= SEQ_ISSUE;
                        draw_start <= 1'b1;
                        draw_index <= head[ENTRY_W-1:DATA_W];
                        draw_data  <= head[DATA_W-1:0];
                        busy       <= 1'b1;
                    end
                end
                SEQ_ISSUE: begin
                    state <= SEQ_DRAW;
                end
                SEQ_DRAW: begin
                    if (draw_done) begin
                        if (DWELL_CYCLES == 0) begin
                            state <= SEQ_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state     <= SEQ_DWELL;
                            dwell_cnt <= DWELL_LOAD;
                        end
                    end
                end
                SEQ_DWELL: begin
                    if (dwell_cnt == '0) begin
                        state <= SEQ_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end
                end
                default: begin
                    state <= SEQ_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
